// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of an asynchronous slow clock SIN in CLK cycles.
// Optional HIGH_TIME output (synchronised SIN high cycles per period) under CLK_PERIOD_METER_HIGH_TIME_EN.
module clk_period_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,        // legal range 2..4
    parameter int TIMEOUT     = 1048576   // must be < 2**CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SIN,
    output logic [CNT_W-1:0] PERIOD,
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
    output logic [CNT_W-1:0] HIGH_TIME,
`endif
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic             OVERRUN,
    output logic             STALLED,
    output logic             STATE_DBG
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sin_s;
    logic                   rise;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             capture;
    logic             stall_set;
    logic             stall_clr;
    logic             xfer;
    logic             drop;

    assign sin_s     = sync_q[SYNC_STAGES-1];
    assign rise      = sin_s & ~hist_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign STATE_DBG = state_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SIN};
            hist_q <= sin_s;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first rise after idle is only a reference edge; results come from later rises.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        stall_set = 1'b0;
        stall_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rise && EN) begin
                    state_d   = S_RUN;
                    stall_clr = 1'b1;
                end
            end
            S_RUN: begin
                if (!EN) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (rise) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_inc == TIMEOUT_C) begin
                    stall_set = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] hi_inc;

    assign hi_inc = hi_cnt_q + CNT_W'(1);

    // The rise cycle itself is high; it is counted through hi_inc at capture.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hi_cnt_q <= '0;
        end else if (rise || state_q == S_IDLE) begin
            hi_cnt_q <= '0;
        end else if (sin_s) begin
            hi_cnt_q <= hi_inc;
        end
    end
`endif

    // Handshake: a result transfers in any cycle with RES_VALID && RES_READY; RES_VALID
    // stays high until then, and a capture while the old result is unconsumed is dropped.
    assign xfer = RES_VALID & RES_READY;
    assign drop = capture & RES_VALID & ~RES_READY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PERIOD    <= '0;
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
            HIGH_TIME <= '0;
`endif
            RES_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
            STALLED   <= 1'b0;
        end else begin
            if (drop) begin
                OVERRUN <= 1'b1;
            end else if (capture) begin
                PERIOD    <= cnt_inc;
`ifdef CLK_PERIOD_METER_HIGH_TIME_EN
                HIGH_TIME <= hi_inc;
`endif
                RES_VALID <= 1'b1;
                if (xfer) begin
                    OVERRUN <= 1'b0;
                end
            end else if (xfer) begin
                RES_VALID <= 1'b0;
                OVERRUN   <= 1'b0;
            end

            if (stall_set) begin
                STALLED <= 1'b1;
            end else if (stall_clr) begin
                STALLED <= 1'b0;
            end
        end
    end

endmodule
